clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Set/alarm controller that sequences the team's hours/minutes/seconds time counter. Generates the 1 Hz count enable from the system clock, runs a button-driven edit FSM that stages a new hours/minutes value and loads it into the counter, and holds and compares an alarm time. Sits between debounced front-panel buttons and the loadable time-counter datapath; also drives the display mux.

## Interface
- TICK_DIV, 50_000_000, clk cycles per `tick`; legal range ≥ 2.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mode_btn / inc_btn / cancel_btn / alarm_btn  in  1 each  single-cycle press pulses, debounced upstream.
- cur_hrs  in  5  counter hours, 0–23.
- cur_min  in  6  counter minutes, 0–59.
- cur_sec  in  6  counter seconds, 0–59.
- tick  out  1  one-cycle count enable to counter, registered.
- load  out  1  one-cycle load strobe to counter, registered.
- load_hrs  out  5  hours value, valid when `load`=1.
- load_min  out  6  minutes value, valid when `load`=1; counter seconds forced to 0 on load.
- disp_hrs / disp_min  out  5 / 6  cur_* in RUN, else edit registers.
- edit_mode  out  2  0 RUN, 1 hours field, 2 minutes field, 3 COMMIT.
- alarm_en  out  1  alarm armed.
- alarm_ring  out  1  alarm sounding.

## Operation
- States: RUN, SET_HRS, SET_MIN, COMMIT, AL_HRS, AL_MIN.
- Per-cycle button priority: cancel > mode > alarm > inc. Only the highest-priority press acts; others are dropped.
- RUN: prescaler counts 0..TICK_DIV-1; `tick`=1 for the cycle after count reaches TICK_DIV-1.
  - mode_btn → SET_HRS; edit_hrs/edit_min ← cur_hrs/cur_min.
  - alarm_btn → AL_HRS; edit regs ← al_hrs/al_min.
  - inc_btn toggles alarm_en.
- SET_HRS / AL_HRS: inc_btn: edit_hrs = 23 ? 0 : +1. mode_btn → SET_MIN / AL_MIN.
- SET_MIN / AL_MIN: inc_btn: edit_min = 59 ? 0 : +1.
  - SET_MIN mode_btn → COMMIT.
  - AL_MIN mode_btn → RUN with al_hrs/al_min ← edit regs; no load.
- COMMIT: lasts one cycle, then RUN. All buttons ignored.
- cancel_btn in any SET_*/AL_* state → RUN; no load, alarm regs unchanged.
- Prescaler: held at 0 and `tick` forced 0 in every state except RUN. It restarts from 0 on re-entering RUN, with or without a commit.
- Alarm match: RUN and alarm_en and cur_hrs==al_hrs and cur_min==al_min and cur_sec==0 sets alarm_ring. Match is checked only on `tick` cycles, so it fires once per match second.
- alarm_ring clears on any button press; that press is consumed with no other effect. Clearing alarm_en also clears it.
- alarm_ring does not block edits; a mode_btn that clears it does not enter SET_HRS.

## Timing
- Reset values:
  - State RUN, prescaler 0.
  - tick=0, load=0, load_hrs=0, load_min=0.
  - Edit regs 0; al_hrs=0, al_min=0.
  - alarm_en=0, alarm_ring=0, edit_mode=0.
- Reset mid-edit discards staged values; no load is issued.
- A button pulse at edge N changes state and edit regs at edge N (visible cycle N+1).
- Commit sequence:
  - mode_btn in SET_MIN at cycle N → COMMIT during N+1, with `load`=1 and load_hrs/min = edit regs.
  - RUN from N+2; first `tick` at cycle N+2+TICK_DIV.
- First tick after reset: TICK_DIV cycles after rst deasserts.
- `tick` and `load` are never high in the same cycle.
- Counter increments only on `tick`. This block assumes cur_* update the cycle after `tick` and after `load`.
- alarm_ring rises the cycle after the matching `tick` edge.

## Structure
- Package clock_ctrl_pkg:
  - state enum.
  - HRS_MAX=23, MIN_MAX=59.
  - HRS_W=5, MIN_W=6, SEC_W=6.
  - edit_mode encodings.
- Sub-module tick_prescaler: params TICK_DIV; ports clk, rst, en, tick. Clears when en=0.
- The time counter gains `tick`/`load` inputs. That change lives in the counter, not here.

## Test plan
All with TICK_DIV=4.
- Reset, then idle 12 cycles → `tick` pulses at cycles 4, 8, 12. load=0, edit_mode=0.
- Set hours:
  - cur=22:15. Press mode, inc ×2, mode, mode.
  - Required: edit_hrs 22→23→0. Exactly one `load` cycle with load_hrs=0, load_min=15.
  - No tick from mode press until RUN+4.
- Minute wrap: in SET_MIN with edit_min=59, press inc → edit_min=0, edit_hrs unchanged.
- Cancel: in SET_MIN, press cancel and mode in the same cycle → RUN, no load, prescaler restarts from 0.
- Alarm:
  - Set alarm 07:30 via alarm_btn path, then inc in RUN (alarm_en=1).
  - Drive cur=07:30:00 on a tick cycle → alarm_ring=1 next cycle.
  - Press inc → alarm_ring=0, alarm_en stays 1.
- Reset mid-edit: rst asserted in SET_HRS for 1 cycle → state RUN, all outputs at reset values, no load.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock set/alarm controller: state encoding,
// field widths and limits, edit_mode codes, and the wrap-around field increments.
package clock_ctrl_pkg;

    localparam int HRS_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [2:0] {
        S_RUN,
        S_SET_HRS,
        S_SET_MIN,
        S_COMMIT,
        S_AL_HRS,
        S_AL_MIN
    } state_t;

    typedef enum logic [1:0] {
        EM_RUN    = 2'd0,
        EM_HRS    = 2'd1,
        EM_MIN    = 2'd2,
        EM_COMMIT = 2'd3
    } edit_mode_t;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
    } hm_t;

    // Out-of-range values (only possible from a misbehaving counter) wrap to 0 as well.
    function automatic logic [HRS_W-1:0] inc_hrs(input logic [HRS_W-1:0] h);
        return (h >= HRS_MAX) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + 1'b1;
    endfunction

    function automatic edit_mode_t edit_mode_of(input state_t s);
        case (s)
            S_SET_HRS, S_AL_HRS: return EM_HRS;
            S_SET_MIN, S_AL_MIN: return EM_MIN;
            S_COMMIT:            return EM_COMMIT;
            default:             return EM_RUN;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every TICK_DIV cycles
// while enabled; dropping en clears the count so the next run starts from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller for the time counter: 1 Hz enable, button-driven
// set/alarm edit FSM with a one-cycle load strobe, and alarm match/ring logic.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_btn,
    input  logic             inc_btn,
    input  logic             cancel_btn,
    input  logic             alarm_btn,
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    output logic             tick,
    output logic             load,
    output logic [HRS_W-1:0] load_hrs,
    output logic [MIN_W-1:0] load_min,
    output logic [HRS_W-1:0] disp_hrs,
    output logic [MIN_W-1:0] disp_min,
    output logic [1:0]       edit_mode,
    output logic             alarm_en,
    output logic             alarm_ring
);

    state_t state_q, state_d;
    hm_t    edit_q, edit_d;
    hm_t    al_q, al_d;
    hm_t    load_val_q, load_val_d;
    logic   load_q, load_d;
    logic   alarm_en_q, alarm_en_d;
    logic   ring_q, ring_d;
    logic   any_btn, match, presc_en;

    assign any_btn = mode_btn | inc_btn | cancel_btn | alarm_btn;

    // Compared while the tick is high, before the counter has advanced on it.
    assign match = tick && (state_q == S_RUN) && alarm_en_q &&
                   (cur_hrs == al_q.hrs) && (cur_min == al_q.min) && (cur_sec == '0);

    // Gate on the next state too, so a tick can never land in the first edit cycle.
    assign presc_en = (state_q == S_RUN) && (state_d == S_RUN);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            edit_q     <= '0;
            al_q       <= '0;
            load_val_q <= '0;
            load_q     <= 1'b0;
            alarm_en_q <= 1'b0;
            ring_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_q     <= edit_d;
            al_q       <= al_d;
            load_val_q <= load_val_d;
            load_q     <= load_d;
            alarm_en_q <= alarm_en_d;
            ring_q     <= ring_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        al_d       = al_q;
        load_val_d = load_val_q;
        load_d     = 1'b0;
        alarm_en_d = alarm_en_q;
        ring_d     = ring_q;

        if (state_q == S_COMMIT) begin
            state_d = S_RUN;
        end else if (ring_q && any_btn) begin
            // Silencing press is swallowed whole.
            ring_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!cancel_btn) begin
                        if (mode_btn) begin
                            state_d = S_SET_HRS;
                            edit_d  = '{hrs: cur_hrs, min: cur_min};
                        end else if (alarm_btn) begin
                            state_d = S_AL_HRS;
                            edit_d  = al_q;
                        end else if (inc_btn) begin
                            alarm_en_d = !alarm_en_q;
                        end
                    end
                end
                S_SET_HRS, S_AL_HRS: begin
                    if (cancel_btn)
                        state_d = S_RUN;
                    else if (mode_btn)
                        state_d = (state_q == S_SET_HRS) ? S_SET_MIN : S_AL_MIN;
                    else if (inc_btn && !alarm_btn)
                        edit_d.hrs = inc_hrs(edit_q.hrs);
                end
                S_SET_MIN: begin
                    if (cancel_btn) begin
                        state_d = S_RUN;
                    end else if (mode_btn) begin
                        state_d    = S_COMMIT;
                        load_d     = 1'b1;
                        load_val_d = edit_q;
                    end else if (inc_btn && !alarm_btn) begin
                        edit_d.min = inc_min(edit_q.min);
                    end
                end
                S_AL_MIN: begin
                    if (cancel_btn) begin
                        state_d = S_RUN;
                    end else if (mode_btn) begin
                        state_d = S_RUN;
                        al_d    = edit_q;
                    end else if (inc_btn && !alarm_btn) begin
                        edit_d.min = inc_min(edit_q.min);
                    end
                end
                default: state_d = S_RUN;
            endcase
        end

        if (match && !(ring_q && any_btn))
            ring_d = 1'b1;
        if (!alarm_en_d)
            ring_d = 1'b0;
    end

    assign load       = load_q;
    assign load_hrs   = load_val_q.hrs;
    assign load_min   = load_val_q.min;
    assign disp_hrs   = (state_q == S_RUN) ? cur_hrs : edit_q.hrs;
    assign disp_min   = (state_q == S_RUN) ? cur_min : edit_q.min;
    assign edit_mode  = edit_mode_of(state_q);
    assign alarm_en   = alarm_en_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=4; loads are checked against
// a scoreboard queue filled at the commit press.
module tb_clock_set_ctrl;
    import clock_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, mode_btn, inc_btn, cancel_btn, alarm_btn;
    logic [4:0] cur_hrs, load_hrs, disp_hrs;
    logic [5:0] cur_min, cur_sec, load_min, disp_min;
    logic [1:0] edit_mode;
    logic       tick, load, alarm_en, alarm_ring;

    int vectors = 0;
    int miscompares = 0;
    hm_t ldq[$];

    clock_set_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .cancel_btn(cancel_btn), .alarm_btn(alarm_btn), .cur_hrs(cur_hrs),
        .cur_min(cur_min), .cur_sec(cur_sec), .tick(tick), .load(load),
        .load_hrs(load_hrs), .load_min(load_min), .disp_hrs(disp_hrs),
        .disp_min(disp_min), .edit_mode(edit_mode), .alarm_en(alarm_en),
        .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic c, input logic a);
        mode_btn = m; inc_btn = i; cancel_btn = c; alarm_btn = a;
        cycle();
        mode_btn = 0; inc_btn = 0; cancel_btn = 0; alarm_btn = 0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tick"}, tick, 0);
        chk({pfx, "_load"}, load, 0);
        chk({pfx, "_load_hrs"}, load_hrs, 0);
        chk({pfx, "_load_min"}, load_min, 0);
        chk({pfx, "_edit_mode"}, edit_mode, 0);
        chk({pfx, "_alarm_en"}, alarm_en, 0);
        chk({pfx, "_alarm_ring"}, alarm_ring, 0);
    endtask

    // Load scoreboard plus tick/load exclusivity, sampled 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        chk("tick_load_excl", {31'd0, tick & load}, 0);
        if (load) begin
            if (ldq.size() == 0) begin
                chk("load_unexpected", 1, 0);
            end else begin
                hm_t e;
                e = ldq.pop_front();
                chk("load_hrs", load_hrs, e.hrs);
                chk("load_min", load_min, e.min);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1; mode_btn = 0; inc_btn = 0; cancel_btn = 0; alarm_btn = 0;
        cur_hrs = 0; cur_min = 0; cur_sec = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_reset_outputs("reset");

        // Idle: ticks at cycles 4, 8, 12 after reset.
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk($sformatf("idle_tick_c%0d", k), tick, (k % 4 == 0));
            chk("idle_load", load, 0);
            chk("idle_edit_mode", edit_mode, 0);
        end

        // Set hours from 22:15, wrapping 23 -> 0, then commit.
        cur_hrs = 22; cur_min = 15; cur_sec = 7;
        press(1, 0, 0, 0);
        chk("set_enter_mode", edit_mode, 1);
        chk("set_enter_hrs", disp_hrs, 22);
        chk("set_no_tick", tick, 0);
        press(0, 1, 0, 0);
        chk("set_inc1_hrs", disp_hrs, 23);
        press(0, 1, 0, 0);
        chk("set_inc2_hrs", disp_hrs, 0);
        press(1, 0, 0, 0);
        chk("set_min_mode", edit_mode, 2);
        chk("set_min_val", disp_min, 15);
        ldq.push_back('{hrs: 5'd0, min: 6'd15});
        press(1, 0, 0, 0);
        chk("commit_mode", edit_mode, 3);
        chk("commit_load", load, 1);
        cycle();
        chk("commit_back_run", edit_mode, 0);
        chk("commit_load_drop", load, 0);
        chk("commit_tick_n2", tick, 0);
        for (int j = 3; j <= 6; j++) begin
            cycle();
            chk($sformatf("commit_tick_n%0d", j), tick, (j == 6));
        end

        // Minute wrap then cancel+mode together.
        cur_hrs = 10; cur_min = 59;
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        chk("wrap_in_min", edit_mode, 2);
        chk("wrap_min_before", disp_min, 59);
        press(0, 1, 0, 0);
        chk("wrap_min_after", disp_min, 0);
        chk("wrap_hrs_kept", disp_hrs, 10);
        press(1, 0, 1, 0);
        chk("cancel_to_run", edit_mode, 0);
        chk("cancel_no_load", load, 0);
        for (int j = 2; j <= 5; j++) begin
            cycle();
            chk($sformatf("cancel_tick_m%0d", j), tick, (j == 5));
        end

        // Alarm 07:30 via the alarm path.
        press(0, 0, 0, 1);
        chk("al_enter_mode", edit_mode, 1);
        chk("al_enter_hrs", disp_hrs, 0);
        chk("al_enter_min", disp_min, 0);
        repeat (7) press(0, 1, 0, 0);
        chk("al_hrs7", disp_hrs, 7);
        press(1, 0, 0, 0);
        repeat (30) press(0, 1, 0, 0);
        chk("al_min30", disp_min, 30);
        press(1, 0, 0, 0);
        chk("al_store_run", edit_mode, 0);
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        chk("al_cancel_inc", disp_hrs, 8);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        chk("al_kept_hrs", disp_hrs, 7);
        chk("al_kept_min", disp_min, 30);
        press(0, 0, 1, 0);
        cur_hrs = 7; cur_min = 30; cur_sec = 1;
        press(0, 1, 0, 0);
        chk("alarm_en_on", alarm_en, 1);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle();
            if (tick) found = 1;
        end
        chk("alarm_tick_seen", found, 1);
        cur_sec = 0;
        chk("ring_before", alarm_ring, 0);
        cycle();
        cur_sec = 1;
        chk("ring_set", alarm_ring, 1);
        press(0, 1, 0, 0);
        chk("ring_cleared", alarm_ring, 0);
        chk("ring_en_kept", alarm_en, 1);
        repeat (5) cycle();
        chk("ring_no_refire", alarm_ring, 0);

        // Reset while editing hours.
        press(1, 0, 0, 0);
        chk("rst_edit_mode", edit_mode, 1);
        rst = 1;
        cycle();
        rst = 0;
        chk_reset_outputs("rst_mid");
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk($sformatf("rst_tick_c%0d", k), tick, (k == 4));
        end
        press(0, 0, 0, 1);
        chk("rst_al_hrs", disp_hrs, 0);
        chk("rst_al_min", disp_min, 0);
        press(0, 0, 1, 0);
        cycle();

        chk("load_queue_empty", ldq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
